// File: rtl/frame_crc_monitor.sv
// frame_crc_monitor: passive tap on the RGB332 pixel stream.
// Folds every active pixel byte into a CRC-32/BZIP2 (poly 0x04C11DB7,
// MSB-first, init/xorout 0xFFFFFFFF). At each vertical-sync boundary it
// latches the CRC, the pixel count and a frame counter, and presents them
// to a reader through a valid/ack handshake.
// Optional macro FRAME_CRC_PIXCHK_EN adds a per-frame geometry check
// (line count, pixels per line, total pixels) reported on geom_err.
module frame_crc_monitor #(
  parameter int H_RES = 320,
  parameter int V_RES = 200,
  parameter bit V_POL = 1'b0
) (
  input  logic        vga_clk,
  input  logic        nreset,
  input  logic [2:0]  pix_r,
  input  logic [2:0]  pix_g,
  input  logic [1:0]  pix_b,
  input  logic        pix_de,
  input  logic        pix_vs,
  input  logic        capture_en,
  input  logic        crc_ack,
  output logic [31:0] crc_out,
  output logic [16:0] pix_count,
  output logic [15:0] frame_cnt,
  output logic        crc_valid,
  output logic        overrun,
  output logic        geom_err
);

  localparam logic [0:0]  S_IDLE   = 1'b0;
  localparam logic [0:0]  S_ACCUM  = 1'b1;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [16:0] CNT_MAX  = 17'h1_FFFF;

  // A geometry that cannot be represented by pix_count is a build error.
  if (H_RES < 1 || V_RES < 1 || H_RES * V_RES > 131071) begin : g_bad_geom
    $error("frame_crc_monitor: H_RES*V_RES must be 1..131071");
  end

  // Fold one byte into the running CRC, MSB first.
  function automatic logic [31:0] crc_fold(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  logic [0:0]  state;
  logic        vs_d;
  logic [31:0] run_crc;
  logic [16:0] run_cnt;

  logic [7:0]  pix_byte;
  logic        accum;
  logic        boundary;
  logic        fold;
  logic        new_res;
  logic [31:0] base_crc;
  logic [16:0] base_cnt;

  assign pix_byte = {pix_r, pix_g, pix_b};
  assign accum    = (state == S_ACCUM);
  // Boundary: pix_vs enters its active level this cycle.
  assign boundary = (pix_vs == V_POL) && (vs_d != V_POL);
  assign fold     = accum && pix_de;
  assign new_res  = accum && boundary;
  // A pixel on the boundary cycle starts the next frame, so it folds into
  // freshly initialised accumulators rather than the finishing ones.
  assign base_crc = boundary ? CRC_INIT : run_crc;
  assign base_cnt = boundary ? '0 : run_cnt;

  // Sync edge detect, capture state and running CRC/count.
  always_ff @(posedge vga_clk or negedge nreset) begin
    if (!nreset) begin
      vs_d    <= ~V_POL;
      state   <= S_IDLE;
      run_crc <= CRC_INIT;
      run_cnt <= '0;
    end else begin
      vs_d <= pix_vs;
      if (boundary) state <= capture_en ? S_ACCUM : S_IDLE;
      if (fold) begin
        run_crc <= crc_fold(base_crc, pix_byte);
        run_cnt <= (base_cnt == CNT_MAX) ? CNT_MAX : base_cnt + 17'd1;
      end else if (boundary) begin
        run_crc <= CRC_INIT;
        run_cnt <= '0;
      end
    end
  end

  // Result registers and the valid/ack/overrun handshake.
  always_ff @(posedge vga_clk or negedge nreset) begin
    if (!nreset) begin
      crc_out   <= '0;
      pix_count <= '0;
      frame_cnt <= '0;
      crc_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (new_res) begin
      crc_out   <= ~run_crc;
      pix_count <= run_cnt;
      frame_cnt <= frame_cnt + 16'd1;
      crc_valid <= 1'b1;
      // An ack in the same cycle consumes the old result, so nothing is lost.
      if (crc_valid && !crc_ack) overrun <= 1'b1;
    end else if (crc_ack && crc_valid) begin
      crc_valid <= 1'b0;
    end
  end

`ifdef FRAME_CRC_PIXCHK_EN
  localparam logic [16:0] H_RES_L   = 17'(H_RES);
  localparam logic [15:0] V_RES_L   = 16'(V_RES);
  localparam logic [16:0] FRAME_PIX = 17'(H_RES * V_RES);

  logic        de_d;
  logic [15:0] line_cnt;
  logic [16:0] line_pix;
  logic        line_err;
  logic        de_rise;
  logic        de_fall;
  logic        err_now;
  logic        new_line;

  assign de_rise  = pix_de && !de_d;
  assign de_fall  = !pix_de && de_d;
  // Include a short line ending on this very cycle.
  assign err_now  = line_err || (accum && de_fall && (line_pix != H_RES_L));
  assign new_line = boundary ? (accum && capture_en && de_rise) : de_rise;

  // Per-line and per-frame geometry tracking, latched with each result.
  always_ff @(posedge vga_clk or negedge nreset) begin
    if (!nreset) begin
      de_d     <= 1'b0;
      line_cnt <= '0;
      line_pix <= '0;
      line_err <= 1'b0;
      geom_err <= 1'b0;
    end else begin
      de_d <= pix_de;
      if (new_res)
        geom_err <= err_now || (line_cnt != V_RES_L) || (run_cnt != FRAME_PIX);
      if (boundary) begin
        line_err <= 1'b0;
        line_cnt <= new_line ? 16'd1 : 16'd0;
        line_pix <= new_line ? 17'd1 : 17'd0;
      end else if (accum) begin
        line_err <= err_now;
        if (new_line) begin
          line_cnt <= line_cnt + 16'd1;
          line_pix <= 17'd1;
        end else if (pix_de && line_pix != CNT_MAX) begin
          line_pix <= line_pix + 17'd1;
        end
      end
    end
  end
`else
  assign geom_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_crc_monitor.sv
// Bench for frame_crc_monitor: directed sequence plus randomized frames,
// checked against a transaction-level model (byte queue per frame, table
// driven CRC, handshake bookkeeping at each frame boundary).
module tb_frame_crc_monitor;
  localparam int HR = 16;
  localparam int VR = 4;

  logic        vga_clk = 1'b0;
  logic        nreset;
  logic [2:0]  pix_r, pix_g;
  logic [1:0]  pix_b;
  logic        pix_de, pix_vs, capture_en, crc_ack;
  logic [31:0] crc_out;
  logic [16:0] pix_count;
  logic [15:0] frame_cnt;
  logic        crc_valid, overrun, geom_err;

  frame_crc_monitor #(.H_RES(HR), .V_RES(VR), .V_POL(1'b0)) dut (
    .vga_clk(vga_clk), .nreset(nreset), .pix_r(pix_r), .pix_g(pix_g),
    .pix_b(pix_b), .pix_de(pix_de), .pix_vs(pix_vs), .capture_en(capture_en),
    .crc_ack(crc_ack), .crc_out(crc_out), .pix_count(pix_count),
    .frame_cnt(frame_cnt), .crc_valid(crc_valid), .overrun(overrun),
    .geom_err(geom_err)
  );

  always #5 vga_clk = ~vga_clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] tbl [256];
  logic [7:0]  fq [$];
  int          lens [$];
  bit          capturing;
  logic [31:0] exp_crc;
  logic [16:0] exp_cnt;
  logic [15:0] exp_fcnt;
  logic        exp_valid, exp_ovr, exp_geom;

  function automatic logic [31:0] ref_crc();
    logic [31:0] c;
    logic [7:0]  idx;
    c = 32'hFFFF_FFFF;
    foreach (fq[i]) begin
      idx = c[31:24] ^ fq[i];
      c = {c[23:0], 8'h00} ^ tbl[idx];
    end
    return ~c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".crc_out"},   crc_out,          exp_crc);
    chk({tag, ".pix_count"}, {15'd0, pix_count}, {15'd0, exp_cnt});
    chk({tag, ".frame_cnt"}, {16'd0, frame_cnt}, {16'd0, exp_fcnt});
    chk({tag, ".crc_valid"}, {31'd0, crc_valid}, {31'd0, exp_valid});
    chk({tag, ".overrun"},   {31'd0, overrun},   {31'd0, exp_ovr});
    chk({tag, ".geom_err"},  {31'd0, geom_err},  {31'd0, exp_geom});
  endtask

  task automatic model_reset();
    exp_crc = '0; exp_cnt = '0; exp_fcnt = '0;
    exp_valid = 0; exp_ovr = 0; exp_geom = 0;
    capturing = 0;
    fq.delete(); lens.delete();
  endtask

  // mode 0: random bytes, 1: constant val, 2: incrementing from val
  task automatic line(input int n, input int mode, input logic [7:0] val);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      @(negedge vga_clk);
      case (mode)
        0:       b = 8'($urandom);
        1:       b = val;
        default: b = val + 8'(i);
      endcase
      pix_de = 1'b1;
      {pix_r, pix_g, pix_b} = b;
      if (capturing) fq.push_back(b);
    end
    if (capturing && n > 0) lens.push_back(n);
    @(negedge vga_clk);
    pix_de = 1'b0;
    repeat (2) @(negedge vga_clk);
  endtask

  task automatic frame(input int nlines, input int len, input int mode, input logic [7:0] val);
    for (int l = 0; l < nlines; l++) line(len, mode, val);
  endtask

  task automatic boundary(input string tag, input bit ack);
    bit bad;
    if (capturing) begin
      exp_crc  = ref_crc();
      exp_cnt  = (fq.size() > 131071) ? 17'h1FFFF : 17'(fq.size());
      exp_fcnt = exp_fcnt + 16'd1;
      if (exp_valid && !ack) exp_ovr = 1'b1;
      exp_valid = 1'b1;
`ifdef FRAME_CRC_PIXCHK_EN
      bad = (lens.size() != VR) || (fq.size() != HR * VR);
      foreach (lens[i]) if (lens[i] != HR) bad = 1;
      exp_geom = bad;
`else
      bad = 0;
      exp_geom = bad;
`endif
    end else if (ack && exp_valid) begin
      exp_valid = 1'b0;
    end
    capturing = capture_en;
    fq.delete(); lens.delete();
    @(negedge vga_clk);
    pix_vs  = 1'b0;
    crc_ack = ack;
    @(negedge vga_clk);
    crc_ack = 1'b0;
    check_all(tag);
    @(negedge vga_clk);
    pix_vs = 1'b1;
    repeat (2) @(negedge vga_clk);
  endtask

  task automatic do_ack(input string tag);
    @(negedge vga_clk);
    crc_ack = 1'b1;
    @(negedge vga_clk);
    crc_ack = 1'b0;
    exp_valid = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] v;
    for (int b = 0; b < 256; b++) begin
      v = 32'(b) << 24;
      for (int k = 0; k < 8; k++) v = v[31] ? ((v << 1) ^ 32'h04C11DB7) : (v << 1);
      tbl[b] = v;
    end

    nreset = 1'b0; pix_vs = 1'b1; pix_de = 1'b0; capture_en = 1'b0; crc_ack = 1'b0;
    {pix_r, pix_g, pix_b} = 8'h00;
    model_reset();
    repeat (2) @(negedge vga_clk);
    check_all("reset");
    nreset = 1'b1;
    repeat (2) @(negedge vga_clk);

    // Reset mid-ACCUM while a result is valid
    capture_en = 1'b1;
    boundary("start0", 0);
    frame(3, 7, 0, 8'h00);
    boundary("pre_reset", 0);
    line(5, 0, 8'h00);
    @(negedge vga_clk);
    pix_de = 1'b1;
    @(negedge vga_clk);
    nreset = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge vga_clk);
    pix_de = 1'b0;
    nreset = 1'b1;
    // Frame in progress at reset is discarded; first boundary only arms capture
    frame(2, 6, 0, 8'h00);
    boundary("post_reset_b1", 0);

    // Known answer "123456789"
    line(9, 2, 8'h31);
    boundary("kat", 0);
    chk("kat.const_crc", crc_out, 32'hFC891918);
    do_ack("kat_ack");

    // Empty frame
    boundary("empty", 0);
    chk("empty.const_crc", crc_out, 32'h0000_0000);

    // Ack coinciding with a new result: overrun must not set
    frame(2, 5, 0, 8'h00);
    boundary("ack_same_cycle", 1);
    // Second result without ack: overrun
    frame(2, 4, 0, 8'h00);
    boundary("overrun", 0);
    // Ack on the boundary of a third frame
    frame(1, 8, 0, 8'h00);
    boundary("ack_third", 1);
    do_ack("ack_clear");
    do_ack("ack_idle");

    // Full-geometry frame of constant 0xE3, then one short line
    frame(VR, HR, 1, 8'hE3);
    boundary("full_geom", 0);
    frame(1, HR, 1, 8'hE3);
    line(HR - 1, 1, 8'hE3);
    frame(VR - 2, HR, 1, 8'hE3);
    boundary("short_line", 0);
`ifdef FRAME_CRC_PIXCHK_EN
    chk("short_line.geom_const", {31'd0, geom_err}, 32'd1);
`endif

    // capture_en dropped mid-frame: frame still reported, then IDLE
    frame(2, 6, 0, 8'h00);
    capture_en = 1'b0;
    frame(2, 6, 0, 8'h00);
    boundary("drop_report", 0);
    frame(3, 6, 0, 8'h00);
    boundary("idle_no_result", 0);
    do_ack("idle_ack");
    // capture_en raised mid-frame: that frame is not reported
    frame(1, 5, 0, 8'h00);
    capture_en = 1'b1;
    frame(1, 5, 0, 8'h00);
    boundary("rise_arm", 0);
    frame(2, 7, 0, 8'h00);
    boundary("rise_first", 0);

    // Randomized frames, capture decisions and acks
    for (int it = 0; it < 12; it++) begin
      frame($urandom_range(0, 5), $urandom_range(1, 20), 0, 8'h00);
      capture_en = ($urandom_range(0, 3) != 0);
      boundary($sformatf("rand%0d", it), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) do_ack($sformatf("rand_ack%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/frame_crc_monitor.md
Name: frame_crc_monitor

Overview:
- Passive tap on the final pixel stream of the frame synthesizer: the RGB332 pixel bus, display enable and sync outputs.
- Computes a CRC-32 over every active pixel of each frame and latches it at frame end, together with pixel and frame counts.
- Results are handed to a reader through a valid/ack handshake.
- Used for simulation regression and for on-board self-test of the video path.
- Lives in the vga_clk domain alongside the frame synthesizer; never drives the video outputs.

Parameters:
- H_RES, 320, active pixels per line (used only by the optional check)
- V_RES, 200, active lines per frame (used only by the optional check)
- V_POL, 0, vertical sync polarity of pix_vs (0: active-low, 1: active-high)

Ports:
- vga_clk  in  1  pixel clock; all logic on rising edge
- nreset  in  1  asynchronous active-low reset
- pix_r  in  3  red of current pixel
- pix_g  in  3  green of current pixel
- pix_b  in  2  blue of current pixel
- pix_de  in  1  display enable; pixel valid when 1
- pix_vs  in  1  vertical sync, polarity per V_POL
- capture_en  in  1  capture request, sampled at each frame boundary
- crc_ack  in  1  one-cycle pulse consuming the current result
- crc_out  out  32  CRC of last completed frame
- pix_count  out  17  active pixels counted in last completed frame, saturating at 131071
- frame_cnt  out  16  completed captured frames, wraps
- crc_valid  out  1  result available
- overrun  out  1  sticky: a result was overwritten while unacknowledged
- geom_err  out  1  per-result geometry mismatch flag (optional feature)

Behaviour:
- Reset (async, nreset=0): crc_out=0, pix_count=0, frame_cnt=0, crc_valid=0, overrun=0, geom_err=0. Running CRC=0xFFFFFFFF, state=IDLE, vs_d=inactive level.
- Pixel byte: {pix_r, pix_g, pix_b}, MSB = pix_r[2].
- CRC algorithm: CRC-32/BZIP2, poly 0x04C11DB7, MSB-first, non-reflected, init 0xFFFFFFFF, final xor 0xFFFFFFFF.
- One byte is folded per clock while pix_de=1 and state=ACCUM. Running pixel count increments on the same cycles and saturates at 131071.
- Frame boundary: vs_d registered each cycle; boundary = pix_vs goes from inactive to active level.
- State IDLE: on boundary, if capture_en=1 -> ACCUM, with running CRC=0xFFFFFFFF and running count=0. Otherwise stay IDLE. Pixels are ignored in IDLE.
- State ACCUM, on boundary, in the same cycle:
  - crc_out <= ~running CRC; pix_count <= running count; frame_cnt <= frame_cnt+1; crc_valid <= 1.
  - Running CRC and count are reinitialised.
  - Next state = ACCUM if capture_en=1, else IDLE.
- Latency: results visible the cycle after the boundary edge is sampled.
- Partial frames: the frame in progress at reset or at capture_en rising is never reported. Capture always starts at a boundary.
- pix_de=1 coinciding with a boundary cycle: that pixel belongs to the new frame (if ACCUM continues). The frame synthesizer never does this; the rule fixes the corner case.
- Handshake:
  - crc_ack with crc_valid=1 clears crc_valid next cycle.
  - crc_ack with crc_valid=0 is ignored.
- New result while crc_valid=1 and no ack in that cycle: result overwritten, crc_valid stays 1, overrun <= 1.
- Ack and new result in the same cycle: new result latched, crc_valid stays 1, overrun unchanged.
- overrun clears only on reset.
- capture_en changes mid-frame have no effect until the next boundary.

Optional Feature:
- Macro: FRAME_CRC_PIXCHK_EN.
- When defined:
  - Line counter increments on each rising edge of pix_de in ACCUM.
  - Per-line pixel counter resets on that edge.
  - line_err (sticky within frame) sets if any line's pixel count != H_RES at its pix_de falling edge.
  - At the boundary: geom_err <= line_err | (lines != V_RES) | (running count != H_RES*V_RES). Latched with each result. Counters and line_err clear at the boundary.
- When undefined: no extra logic; geom_err tied 0.

Test Plan:
- Reset mid-ACCUM with valid=1 -> all outputs 0 immediately. The next frame after reset is discarded, and the first result appears only after two boundaries with capture_en=1.
- capture_en=1; frame of 9 pixels with bytes "123456789" (0x31..0x39); next boundary -> crc_out=0xFC891918, pix_count=9, frame_cnt=1, crc_valid=1.
- Frame with pix_de never asserted -> crc_out=0x00000000, pix_count=0.
- Two frames completed without ack -> overrun=1, crc_out holds second frame's CRC. Ack pulse on the exact boundary cycle of a third frame -> valid stays 1, no additional effect on overrun.
- Full 320x200 frame of constant byte 0xE3 -> pix_count=64000; geom_err=0 with FRAME_CRC_PIXCHK_EN. One line shortened to 319 pixels -> geom_err=1, pix_count=63999.
- capture_en dropped mid-frame -> that frame is still reported. The next boundary enters IDLE; frame_cnt stops incrementing and pixels are ignored.
